pixel_frame_writer: RTL and testbench

//  Downstream of the Ethernet image/audio splitter on FPGA1. Consumes its address strobe and
//  per-byte pixel strobes, then writes each packet's pixels into the frame-buffer BRAM, starting
//  at the packet address. Audio bytes are buffered in a small FIFO for the audio output path.

---
 rtl/pixel_frame_writer.sv | 188 ++++++++++++++++++
 tb/tb_pixel_frame_writer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_frame_writer.sv
// rtl/pixel_frame_writer.sv - packet pixel writer into frame-buffer BRAM with audio byte FIFO
module pixel_frame_writer #(
  parameter int FB_DEPTH       = 76800,
  parameter int PIXELS_PER_PKT = 320,
  parameter int AUDIO_DEPTH    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pkt_axiiv,
  input  logic        addr_axiov,
  input  logic [23:0] addr,
  input  logic        pixel_axiov,
  input  logic [7:0]  pixel,
  input  logic        audio_axiov,
  input  logic [7:0]  audio,
  output logic        fb_we,
  output logic [16:0] fb_addr,
  output logic [7:0]  fb_din,
  output logic        aud_tvalid,
  output logic [7:0]  aud_tdata,
  input  logic        aud_tready,
  output logic        pkt_done,
  output logic        pkt_short,
  output logic [2:0]  err_flags
);

  localparam int AW = $clog2(AUDIO_DEPTH);
  localparam logic [23:0] FB_DEPTH_L = 24'(FB_DEPTH);
  localparam logic [16:0] FB_LAST    = 17'(FB_DEPTH - 1);
  localparam logic [8:0]  PPP        = 9'(PIXELS_PER_PKT);
  localparam logic [AW:0] AUD_FULL   = (AW + 1)'(AUDIO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DROP} state_t;

  state_t      state_q, state_d;
  logic [16:0] wr_ptr_q, wr_ptr_d;
  logic [8:0]  count_q, count_d;
  logic        pkt_q;
  // Set while dropping a packet whose start address was out of range; such a
  // packet reports neither done nor short when it ends.
  logic        addr_drop_q, addr_drop_d;
  logic        fb_we_q, fb_we_d;
  logic [16:0] fb_addr_q, fb_addr_d;
  logic [7:0]  fb_din_q, fb_din_d;
  logic        pkt_done_q, pkt_done_d;
  logic        pkt_short_q, pkt_short_d;
  logic [2:0]  err_q, err_d;
  logic [8:0]  cnt_v;
  logic        pkt_end;

  logic [7:0]    aud_mem_q [AUDIO_DEPTH];
  logic [AW-1:0] aud_rd_q, aud_wr_q;
  logic [AW:0]   aud_fill_q;
  logic          aud_pop, aud_push, aud_full, aud_ovf;

  assign pkt_end  = pkt_q & ~pkt_axiiv;
  assign aud_full = (aud_fill_q == AUD_FULL);
  assign aud_pop  = (aud_fill_q != '0) & aud_tready;
  assign aud_push = audio_axiov & (~aud_full | aud_pop);
  assign aud_ovf  = audio_axiov & aud_full & ~aud_pop;

  // Next-state logic: pixel write first, then packet end / restart, then new address.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    addr_drop_d = addr_drop_q;
    fb_we_d     = 1'b0;
    fb_addr_d   = fb_addr_q;
    fb_din_d    = fb_din_q;
    pkt_done_d  = 1'b0;
    pkt_short_d = 1'b0;
    err_d       = err_q;
    cnt_v       = count_q;

    if (aud_ovf) begin
      err_d[2] = 1'b1;
    end

    if (state_q == S_WRITE && pixel_axiov) begin
      fb_we_d   = 1'b1;
      fb_addr_d = wr_ptr_q;
      fb_din_d  = pixel;
      wr_ptr_d  = wr_ptr_q + 17'd1;
      cnt_v     = (count_q == PPP) ? count_q : count_q + 9'd1;
      count_d   = cnt_v;
      if (wr_ptr_q == FB_LAST) begin
        state_d  = S_DROP;
        err_d[1] = 1'b1;
      end
      if (cnt_v == PPP) begin
        state_d = S_DROP;
      end
    end

    if (state_q != S_IDLE && (pkt_end || addr_axiov)) begin
      if (!addr_drop_q) begin
        if (cnt_v == PPP) begin
          pkt_done_d = pkt_end;
        end else begin
          pkt_short_d = 1'b1;
        end
      end
      state_d     = S_IDLE;
      addr_drop_d = 1'b0;
    end

    if (addr_axiov) begin
      count_d = '0;
      if (addr < FB_DEPTH_L) begin
        wr_ptr_d    = addr[16:0];
        state_d     = S_WRITE;
        addr_drop_d = 1'b0;
      end else begin
        err_d[0]    = 1'b1;
        state_d     = S_DROP;
        addr_drop_d = 1'b1;
      end
    end
  end

  // Packet state and registered frame-buffer / status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      pkt_q       <= 1'b0;
      addr_drop_q <= 1'b0;
      fb_we_q     <= 1'b0;
      fb_addr_q   <= '0;
      fb_din_q    <= '0;
      pkt_done_q  <= 1'b0;
      pkt_short_q <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      pkt_q       <= pkt_axiiv;
      addr_drop_q <= addr_drop_d;
      fb_we_q     <= fb_we_d;
      fb_addr_q   <= fb_addr_d;
      fb_din_q    <= fb_din_d;
      pkt_done_q  <= pkt_done_d;
      pkt_short_q <= pkt_short_d;
      err_q       <= err_d;
    end
  end

  // Audio FIFO storage; contents need no reset since the fill count gates validity.
  always_ff @(posedge clk) begin
    if (aud_push) begin
      aud_mem_q[aud_wr_q] <= audio;
    end
  end

  // Audio FIFO pointers and fill level.
  always_ff @(posedge clk) begin
    if (rst) begin
      aud_rd_q   <= '0;
      aud_wr_q   <= '0;
      aud_fill_q <= '0;
    end else begin
      if (aud_push) begin
        aud_wr_q <= aud_wr_q + AW'(1);
      end
      if (aud_pop) begin
        aud_rd_q <= aud_rd_q + AW'(1);
      end
      case ({aud_push, aud_pop})
        2'b10:   aud_fill_q <= aud_fill_q + (AW + 1)'(1);
        2'b01:   aud_fill_q <= aud_fill_q - (AW + 1)'(1);
        default: aud_fill_q <= aud_fill_q;
      endcase
    end
  end

  assign fb_we      = fb_we_q;
  assign fb_addr    = fb_addr_q;
  assign fb_din     = fb_din_q;
  assign pkt_done   = pkt_done_q;
  assign pkt_short  = pkt_short_q;
  assign err_flags  = err_q;
  assign aud_tvalid = (aud_fill_q != '0);
  assign aud_tdata  = aud_tvalid ? aud_mem_q[aud_rd_q] : 8'h00;

endmodule

// File: tb/tb_pixel_frame_writer.sv
// tb/tb_pixel_frame_writer.sv - self-checking bench for pixel_frame_writer
module tb_pixel_frame_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pkt_axiiv = 1'b0;
  logic        addr_axiov = 1'b0;
  logic [23:0] addr = '0;
  logic        pixel_axiov = 1'b0;
  logic [7:0]  pixel = '0;
  logic        audio_axiov = 1'b0;
  logic [7:0]  audio = '0;
  logic        aud_tready = 1'b0;
  logic        fb_we;
  logic [16:0] fb_addr;
  logic [7:0]  fb_din;
  logic        aud_tvalid;
  logic [7:0]  aud_tdata;
  logic        pkt_done;
  logic        pkt_short;
  logic [2:0]  err_flags;

  pixel_frame_writer dut (
    .clk(clk), .rst(rst), .pkt_axiiv(pkt_axiiv),
    .addr_axiov(addr_axiov), .addr(addr),
    .pixel_axiov(pixel_axiov), .pixel(pixel),
    .audio_axiov(audio_axiov), .audio(audio),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_din(fb_din),
    .aud_tvalid(aud_tvalid), .aud_tdata(aud_tdata), .aud_tready(aud_tready),
    .pkt_done(pkt_done), .pkt_short(pkt_short), .err_flags(err_flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int npix;
    bit gap;
    bit lwe;
    int exp_writes;
    int exp_first;
    int exp_done;
    int exp_short;
    int exp_err;
  } vec_t;

  vec_t vecs[8];
  int   n_checks = 0;
  int   n_err = 0;
  int   done_cnt = 0;
  int   short_cnt = 0;
  int   wq[$];
  int   exq[$];

  // Observe outputs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (fb_we) wq.push_back((int'(fb_addr) << 8) | int'(fb_din));
    if (pkt_done) done_cnt++;
    if (pkt_short) short_cnt++;
  end

  initial begin
    #10000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  function automatic logic [7:0] pix(input int k);
    return 8'((k * 7 + 3) & 255);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pkt_axiiv = 1'b0; addr_axiov = 1'b0; pixel_axiov = 1'b0;
    audio_axiov = 1'b0; aud_tready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    wq.delete(); exq.delete();
    done_cnt = 0; short_cnt = 0;
  endtask

  task automatic start_pkt(input int a);
    pkt_axiiv = 1'b1;
    tick();
    addr_axiov = 1'b1; addr = 24'(a);
    tick();
    addr_axiov = 1'b0;
  endtask

  task automatic send_pixels(input int n, input int idx0, input bit gap, input bit lwe);
    for (int i = 0; i < n; i++) begin
      pixel_axiov = 1'b1;
      pixel = pix(idx0 + i);
      if (lwe && i == n - 1) pkt_axiiv = 1'b0;
      tick();
      pixel_axiov = 1'b0;
      if (gap && i[0]) tick();
    end
  endtask

  task automatic end_pkt();
    pkt_axiiv = 1'b0;
    repeat (4) tick();
  endtask

  task automatic expect_run(input int first, input int n, input int idx0);
    for (int k = 0; k < n; k++) exq.push_back(((first + k) << 8) | int'(pix(idx0 + k)));
  endtask

  task automatic check_writes(input string nm);
    int bad;
    bad = 0;
    chk({nm, "_nwrites"}, wq.size(), exq.size());
    for (int k = 0; k < exq.size() && k < wq.size(); k++)
      if (wq[k] !== exq[k]) bad++;
    chk({nm, "_wrdata_bad"}, bad, 0);
  endtask

  initial begin
    //          addr       npix gap lwe writes first   done short err
    vecs[0] = '{32'h100,   320, 0,  0,  320,   32'h100, 1,  0,    0};
    vecs[1] = '{5,         10,  0,  0,  10,    5,       0,  1,    0};
    vecs[2] = '{76798,     4,   0,  0,  2,     76798,   0,  1,    2};
    vecs[3] = '{32'h20000, 320, 0,  0,  0,     0,       0,  0,    1};
    vecs[4] = '{0,         325, 0,  0,  320,   0,       1,  0,    0};
    vecs[5] = '{1000,      320, 0,  1,  320,   1000,    1,  0,    0};
    vecs[6] = '{2000,      319, 0,  1,  319,   2000,    0,  1,    0};
    vecs[7] = '{76799,     40,  1,  0,  1,     76799,   0,  1,    2};

    do_reset();
    chk("rst_fb_we", int'(fb_we), 0);
    chk("rst_fb_addr", int'(fb_addr), 0);
    chk("rst_fb_din", int'(fb_din), 0);
    chk("rst_aud_tvalid", int'(aud_tvalid), 0);
    chk("rst_aud_tdata", int'(aud_tdata), 0);
    chk("rst_pkt_done", int'(pkt_done), 0);
    chk("rst_pkt_short", int'(pkt_short), 0);
    chk("rst_err", int'(err_flags), 0);

    for (int v = 0; v < 8; v++) begin
      do_reset();
      start_pkt(vecs[v].addr);
      send_pixels(vecs[v].npix, 0, vecs[v].gap, vecs[v].lwe);
      end_pkt();
      expect_run(vecs[v].exp_first, vecs[v].exp_writes, 0);
      check_writes($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_done", v), done_cnt, vecs[v].exp_done);
      chk($sformatf("vec%0d_short", v), short_cnt, vecs[v].exp_short);
      chk($sformatf("vec%0d_err", v), int'(err_flags), vecs[v].exp_err);
    end

    // Pixels with no address are ignored.
    do_reset();
    send_pixels(4, 0, 0, 0);
    tick();
    chk("idle_pixels_writes", wq.size(), 0);

    // Missed packet end: a new address restarts the packet and reports short.
    do_reset();
    start_pkt(10);
    send_pixels(5, 0, 0, 0);
    addr_axiov = 1'b1; addr = 24'd200;
    tick();
    addr_axiov = 1'b0;
    tick();
    chk("restart_short_pulse", short_cnt, 1);
    send_pixels(3, 5, 0, 0);
    end_pkt();
    expect_run(10, 5, 0);
    expect_run(200, 3, 5);
    check_writes("restart");
    chk("restart_short_total", short_cnt, 2);
    chk("restart_done", done_cnt, 0);

    // Audio: fill past capacity, then drain in order.
    do_reset();
    for (int i = 0; i < 18; i++) begin
      audio_axiov = 1'b1; audio = 8'(8'h40 + i);
      tick();
      audio_axiov = 1'b0;
      if (i == 0) chk("aud_valid_latency", int'(aud_tvalid), 1);
    end
    chk("aud_ovf_err", int'(err_flags), 4);
    begin
      int bad;
      bad = 0;
      aud_tready = 1'b1;
      for (int i = 0; i < 16; i++) begin
        if (!aud_tvalid || aud_tdata !== 8'(8'h40 + i)) bad++;
        tick();
      end
      aud_tready = 1'b0;
      chk("aud_drain_bad", bad, 0);
      chk("aud_empty_after_drain", int'(aud_tvalid), 0);
    end

    // Full FIFO: simultaneous push and pop is legal; a lone push overflows.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      audio_axiov = 1'b1; audio = 8'(i);
      tick();
    end
    aud_tready = 1'b1; audio = 8'hAA;
    tick();
    aud_tready = 1'b0; audio_axiov = 1'b0;
    tick();
    chk("aud_full_pushpop_err", int'(err_flags), 0);
    chk("aud_full_head", int'(aud_tdata), 1);
    audio_axiov = 1'b1;
    tick();
    audio_axiov = 1'b0;
    tick();
    chk("aud_full_push_err", int'(err_flags), 4);

    // Reset mid-packet clears everything and aborts the packet.
    do_reset();
    start_pkt(0);
    send_pixels(3, 0, 0, 0);
    for (int i = 0; i < 17; i++) begin
      audio_axiov = 1'b1; audio = 8'(i);
      tick();
    end
    audio_axiov = 1'b0;
    chk("pre_rst_err", int'(err_flags), 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    short_cnt = 0; done_cnt = 0; wq.delete();
    chk("mid_rst_err", int'(err_flags), 0);
    chk("mid_rst_aud_tvalid", int'(aud_tvalid), 0);
    chk("mid_rst_fb_addr", int'(fb_addr), 0);
    pixel_axiov = 1'b1; pixel = 8'h55;
    tick();
    pixel_axiov = 1'b0;
    end_pkt();
    chk("mid_rst_no_writes", wq.size(), 0);
    chk("mid_rst_no_status", short_cnt + done_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
